reg_xfer_sequencer: RTL and testbench
=====================================

# reg_xfer_sequencer

Command sequencer directly upstream of the 8×16-bit `control_reg` register file. It accepts packed transfer commands over a valid/ready handshake and buffers them in a small FIFO. It then drives `control_reg`'s `src`/`dest`/`MOVE`/`IN`/`data_in` inputs, one transfer at a time, with mandatory settle gaps. It guarantees `MOVE` and `IN` are never high together and flags illegal commands.

## Interface
- `DATA_W`, 16, data width; matches `control_reg` `data_in`.
- `DEPTH`, 4, command FIFO depth; power of two, ≥2.
- `SETTLE_CYC`, 1, idle cycles forced after each issued transfer; ≥1.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_data`  in  8+DATA_W  command; bit layout given in Operation.
- `err_clr`  in  1  clears `err`.
- `src`  out  3  to `control_reg`; source register.
- `dest`  out  3  to `control_reg`; destination register.
- `MOVE`  out  1  to `control_reg`; one-cycle move strobe.
- `IN`  out  1  to `control_reg`; one-cycle load strobe.
- `data_in`  out  DATA_W  to `control_reg`; immediate value.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `done`  out  1  one-cycle pulse per completed transfer.
- `err`  out  1  sticky illegal-command flag.

## Operation
- `cmd_data` layout:
  - `[DATA_W+7:DATA_W+6]` op: 00 NOP, 01 IN, 10 MOVE, 11 illegal.
  - `[DATA_W+5:DATA_W+3]` dest.
  - `[DATA_W+2:DATA_W]` src.
  - `[DATA_W-1:0]` imm.
- Handshake: accept when `cmd_valid && cmd_ready`. `cmd_ready = !full`, based on the current count. A pop in the same cycle does not open a slot for a push.
- FSM states are IDLE, ISSUE, SETTLE.
- IDLE with FIFO non-empty pops the head entry:
  - IN → ISSUE. Register `dest`←dest, `data_in`←imm, `IN`←1.
  - MOVE → ISSUE. Register `src`←src, `dest`←dest, `MOVE`←1.
  - NOP → entry discarded. Stay IDLE; no strobe, no `done`.
  - Illegal → entry discarded. `err`←1; stay IDLE.
- ISSUE lasts one cycle. Strobes are cleared at the next edge, `done` pulses for that next cycle, and the FSM enters SETTLE.
- SETTLE lasts `SETTLE_CYC` cycles with both strobes low, then → IDLE.
- `src`, `dest` and `data_in` update only on issue and hold afterwards. On IN, `src` is unchanged; on MOVE, `data_in` is unchanged.
- `MOVE && IN` is never 1 in any cycle.
- `err`: sticky. `err_clr` clears it. If an illegal pop and `err_clr` occur in the same cycle, set wins.

## Timing
- Reset (async assert, sync-safe deassert):
  - All outputs 0 (`src`, `dest`, `data_in`, `MOVE`, `IN`, `done`, `busy`, `err`).
  - `cmd_ready`=1, FIFO empty, FSM IDLE.
- Reset asserted mid-operation flushes the FIFO and drops any strobe or settle immediately.
- Latency with empty FIFO and FSM in IDLE:
  - Command accepted at edge N. Pop occurs at N+1, and the strobe is high from N+1 to N+2.
  - `done` is high from N+2 to N+3.
  - Next issue occurs no earlier than edge N+2+SETTLE_CYC.
- Throughput: one transfer per 2+SETTLE_CYC cycles. NOP and illegal entries each consume one IDLE cycle.
- FIFO full: `cmd_ready`=0. The head pop frees a slot, which is visible the following cycle.
- Pointers wrap modulo `DEPTH`. The count distinguishes full from empty.
- `busy` is combinational from the FIFO count and FSM state.

## Configuration
- `SEQ_SELF_MOVE_DROP_EN` defined: a MOVE with src==dest is treated as a NOP. It is discarded in IDLE with no strobe, no `done` and no `err`.
- Not defined: a self-move issues normally, with `MOVE` pulsed and `done` pulsed.

## Test plan
- Reset mid-stream: 3 commands queued, `rst_n`=0 during ISSUE → all outputs 0 in the same cycle, FIFO empty, no further strobes after release.
- IN: dest=0, imm=9 → `IN` high exactly 1 cycle with `dest`=0, `data_in`=9. `done` follows next cycle. `control_reg` R0 reads 9.
- Back-to-back transfers: MOVE src=0→dest=1, then IN dest=2 imm=15, then MOVE src=2→dest=0, all pushed in consecutive cycles:
  - Strobes are spaced 2+SETTLE_CYC cycles apart.
  - R1=9 and R0=15 at the end.
  - `MOVE&&IN` is never seen.
- Illegal and NOP commands: push op=11, then a NOP, then IN dest=3 imm=7:
  - `err`=1 after the pop; no strobe for the first two.
  - IN issues; `err` stays 1 until `err_clr`.
  - `err_clr` together with a new illegal pop leaves `err`=1.
- Full FIFO: push DEPTH+1 commands while the FSM is busy → `cmd_ready`=0 after DEPTH accepts. The extra command is held by the source and accepted after a pop. Order is preserved across pointer wrap.
- Self-move: MOVE src=4→dest=4 gives no strobe and no `done` with `SEQ_SELF_MOVE_DROP_EN` defined, and one `MOVE` pulse plus `done` without it.

Source files
------------

// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: buffers packed transfer commands and drives control_reg.
// Optional feature macro: SEQ_SELF_MOVE_DROP_EN (discard MOVE with src==dest).
module reg_xfer_sequencer #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W+7:0] cmd_data,
  input  logic              err_clr,
  output logic [2:0]        src,
  output logic [2:0]        dest,
  output logic              MOVE,
  output logic              IN,
  output logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CMD_W = DATA_W + 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam int SW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_IN   = 2'b01;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE
  } state_e;

  logic [CMD_W-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  state_e            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [2:0]        src_q, src_d;
  logic [2:0]        dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              move_q, move_d;
  logic              in_q, in_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              full, empty, push, pop;
  logic [1:0]        h_op;
  logic [2:0]        h_dest, h_src;
  logic [DATA_W-1:0] h_imm;
  logic              self_move;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  assign {h_op, h_dest, h_src, h_imm} = mem_q[rd_ptr_q];

`ifdef SEQ_SELF_MOVE_DROP_EN
  assign self_move = (h_src == h_dest);
`else
  assign self_move = 1'b0;
`endif

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      (push && !pop): count_d = count_q + 1'b1;
      (pop && !push): count_d = count_q - 1'b1;
      default:        count_d = count_q;
    endcase
  end

  // Issue FSM next-state: decode head entry, pulse strobes, enforce settle
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    src_d    = src_q;
    dest_d   = dest_q;
    data_d   = data_q;
    move_d   = 1'b0;
    in_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    if (err_clr) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          unique case (h_op)
            OP_IN: begin
              state_d = S_ISSUE;
              dest_d  = h_dest;
              data_d  = h_imm;
              in_d    = 1'b1;
            end
            OP_MOVE: begin
              if (!self_move) begin
                state_d = S_ISSUE;
                src_d   = h_src;
                dest_d  = h_dest;
                move_d  = 1'b1;
              end
            end
            OP_ILL: err_d = 1'b1;
            OP_NOP: ;
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        done_d   = 1'b1;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) state_d = S_IDLE;
        else settle_d = settle_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage; no reset needed, occupancy guards reads
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_data;
  end

  // FIFO pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      src_q    <= '0;
      dest_q   <= '0;
      data_q   <= '0;
      move_q   <= 1'b0;
      in_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      src_q    <= src_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
      move_q   <= move_d;
      in_q     <= in_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = !full;
  assign src       = src_q;
  assign dest      = dest_q;
  assign data_in   = data_q;
  assign MOVE      = move_q;
  assign IN        = in_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// tb_reg_xfer_sequencer: scoreboard bench for reg_xfer_sequencer.
// Expected transfers are queued at push time and checked by a strobe monitor.
module tb_reg_xfer_sequencer;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_IN   = 2'd1;
  localparam logic [1:0] K_MOVE = 2'd2;

`ifdef SEQ_SELF_MOVE_DROP_EN
  localparam logic [1:0] SELF_K   = K_NONE;
  localparam logic [2:0] LAST_SRC = 3'd2;
`else
  localparam logic [1:0] SELF_K   = K_MOVE;
  localparam logic [2:0] LAST_SRC = 3'd4;
`endif

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  src;
    logic [2:0]  dest;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_data;
  logic        err_clr;
  logic [2:0]  src, dest;
  logic        MOVE, IN;
  logic [15:0] data_in;
  logic        busy, done, err;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   exp_strobes = 0;
  int   last_cyc = -1;
  logic prev_strobe = 1'b0;
  logic spacing_en;
  exp_t sbq[$];
  logic [15:0] rm [8];

  reg_xfer_sequencer #(
    .DATA_W(16), .DEPTH(4), .SETTLE_CYC(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .err_clr(err_clr),
    .src(src), .dest(dest), .MOVE(MOVE), .IN(IN),
    .data_in(data_in), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference control_reg fed by the DUT strobes
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rm[i] <= '0;
    end else if (IN) begin
      rm[dest] <= data_in;
    end else if (MOVE) begin
      rm[dest] <= rm[src];
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [1:0] op,
                                     input logic [2:0] d, input logic [2:0] s,
                                     input logic [15:0] imm);
    return {op, d, s, imm};
  endfunction

  // monitor: compares every strobe against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_strobe <= 1'b0;
      last_cyc    <= -1;
    end else begin
      if (MOVE && IN) check("move_in_excl", 32'd1, 32'd0);
      if (prev_strobe) check("done_after_strobe", {31'd0, done}, 32'd1);
      else if (done) check("done_spurious", 32'd1, 32'd0);
      if (MOVE || IN) begin
        strobe_cnt <= strobe_cnt + 1;
        if (prev_strobe) check("strobe_width", 32'd2, 32'd1);
        if (sbq.size() == 0) begin
          check("unexpected_strobe", {8'd0, MOVE, IN, src, dest, data_in},
                32'd0);
        end else begin
          e = sbq.pop_front();
          check("xfer", {8'd0, MOVE, IN, src, dest, data_in}, {8'd0, e});
        end
        if (spacing_en && last_cyc >= 0)
          check("spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc <= spacing_en ? cyc : -1;
      end else if (!spacing_en) begin
        last_cyc <= -1;
      end
      prev_strobe <= MOVE || IN;
    end
  end

  task automatic push(input logic [23:0] c, input logic [1:0] kind,
                      input logic [2:0] es, input logic [2:0] ed,
                      input logic [15:0] edat, output int stalls);
    stalls = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = c;
    while (!cmd_ready && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      if (kind != K_NONE) begin
        sbq.push_back(exp_t'{kind, es, ed, edat});
        exp_strobes++;
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int n;
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_data   = '0;
    err_clr    = 1'b0;
    spacing_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_src", {29'd0, src}, 32'd0);
    check("rst_dest", {29'd0, dest}, 32'd0);
    check("rst_data", {16'd0, data_in}, 32'd0);
    check("rst_strobes", {30'd0, MOVE, IN}, 32'd0);
    check("rst_flags", {29'd0, done, busy, err}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // single IN
    push(mk(2'b01, 3'd0, 3'd0, 16'd9), K_IN, 3'd0, 3'd0, 16'd9, st);
    wait_idle();
    check("r0_after_in", {16'd0, rm[0]}, 32'd9);

    // back-to-back transfers
    spacing_en = 1'b1;
    push(mk(2'b10, 3'd1, 3'd0, 16'd0), K_MOVE, 3'd0, 3'd1, 16'd9, st);
    push(mk(2'b01, 3'd2, 3'd0, 16'd15), K_IN, 3'd0, 3'd2, 16'd15, st);
    push(mk(2'b10, 3'd0, 3'd2, 16'd0), K_MOVE, 3'd2, 3'd0, 16'd15, st);
    wait_idle();
    spacing_en = 1'b0;
    check("r1_b2b", {16'd0, rm[1]}, 32'd9);
    check("r0_b2b", {16'd0, rm[0]}, 32'd15);
    check("r2_b2b", {16'd0, rm[2]}, 32'd15);

    // illegal, NOP, then IN
    check("err_pre", {31'd0, err}, 32'd0);
    push(mk(2'b11, 3'd5, 3'd5, 16'hdead), K_NONE, 3'd0, 3'd0, 16'd0, st);
    push(mk(2'b00, 3'd6, 3'd6, 16'h0001), K_NONE, 3'd0, 3'd0, 16'd0, st);
    push(mk(2'b01, 3'd3, 3'd0, 16'd7), K_IN, 3'd2, 3'd3, 16'd7, st);
    wait_idle();
    check("err_set", {31'd0, err}, 32'd1);
    check("r3_after_in", {16'd0, rm[3]}, 32'd7);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, err}, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", {31'd0, err}, 32'd0);
    push(mk(2'b11, 3'd1, 3'd1, 16'h0bad), K_NONE, 3'd0, 3'd0, 16'd0, st);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("err_set_wins", {31'd0, err}, 32'd1);
    wait_idle();

    // full FIFO with pointer wrap
    spacing_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push(mk(2'b01, 3'(i), 3'd0, 16'h100 + 16'(i)), K_IN, 3'd2, 3'(i),
           16'h100 + 16'(i), st);
      check($sformatf("stalls_%0d", i), 32'(st), (i == 6) ? 32'd2 : 32'd0);
    end
    wait_idle();
    spacing_en = 1'b0;
    check("r0_full", {16'd0, rm[0]}, 32'h100);
    check("r6_full", {16'd0, rm[6]}, 32'h106);

    // self-move
    push(mk(2'b10, 3'd4, 3'd4, 16'd0), SELF_K, 3'd4, 3'd4, 16'h106, st);
    wait_idle();
    check("strobe_count", 32'(strobe_cnt), 32'(exp_strobes));
    check("r4_self", {16'd0, rm[4]}, 32'h104);

    // reset while the second of three commands is issuing
    push(mk(2'b01, 3'd5, 3'd0, 16'h00aa), K_IN, LAST_SRC, 3'd5, 16'h00aa, st);
    push(mk(2'b01, 3'd6, 3'd0, 16'h00bb), K_NONE, 3'd0, 3'd0, 16'd0, st);
    push(mk(2'b01, 3'd7, 3'd0, 16'h00cc), K_NONE, 3'd0, 3'd0, 16'd0, st);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!(IN && data_in == 16'h00bb) && n < 20);
    check("second_issue_seen", {31'd0, IN}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_strobes", {30'd0, MOVE, IN}, 32'd0);
    check("mid_rst_regs", {8'd0, src, dest, data_in}, 32'd0);
    check("mid_rst_flags", {29'd0, done, busy, err}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_strobes", 32'(strobe_cnt), 32'(exp_strobes));
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
